// File: rtl/pic_inta_sequencer.sv
// ---------------------------------------------------------------------------
// pic_inta_sequencer
//   Interrupt service controller of an 8259-style PIC core. It picks the
//   highest-priority unmasked request (fully nested or auto-rotate ordering),
//   raises int_out, and walks the two-pulse INTA handshake. The first INTA
//   latches the level and sets its ISR bit. The second INTA drives the vector.
//   Non-specific, specific and automatic EOI clear ISR bits and may rotate
//   the priority ring.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   irr, imr      pending requests / mask (1 = masked)
//   inta_n        active-low acknowledge, synchronous to clk
//   eoi, seoi     non-specific / specific EOI pulses; seoi_level selects bit
//   aeoi_mode     clear ISR automatically at the end of the second INTA
//   rotate_mode   make the serviced level the lowest priority on EOI/AEOI
//   vector_base   T7..T3 of the vector byte
//   int_out       interrupt request to the CPU (registered)
//   irr_clr       one-cycle one-hot clear of the accepted IRR bit
//   isr           in-service register
//   data_out      vector byte, data_en = vector valid / bus drive enable
//   lowest_prio   current lowest-priority level
// ---------------------------------------------------------------------------
module pic_inta_sequencer #(
  parameter logic [2:0] RESET_LOWEST_PRIO = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] seoi_level,
  input  logic       aeoi_mode,
  input  logic       rotate_mode,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] irr_clr,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic [2:0] lowest_prio
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_e;

  state_e     state_q, state_d;
  logic       inta_q;
  logic [2:0] sel_q, sel_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic [7:0] irr_clr_q, irr_clr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] dout_q, dout_d;
  logic       den_q, den_d;
  logic [2:0] lp_q, lp_d;

  // Scan the ring from the highest-priority level (lp+1) down to lp.
  // The descending loop leaves the first hit in ring order in r.
  function automatic logic [3:0] pick_hi(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] r;
    logic [2:0] lvl;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      lvl = lp + 3'(i) + 3'd1;
      if (v[lvl]) r = {1'b1, lvl};
    end
    return r;
  endfunction

  logic       fall, rise;
  logic [7:0] req;
  logic [3:0] cand, isr_hi;
  logic [2:0] cand_rank, isr_rank;
  logic       cand_ok;
  logic [7:0] set_mask, clr_mask;

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;
  assign req  = irr & ~imr;

  assign cand   = pick_hi(req, lp_q);
  assign isr_hi = pick_hi(isr_q, lp_q);

  // Rank 0 is the highest priority. Modulo-8 distance from lp+1.
  assign cand_rank = cand[2:0] - lp_q - 3'd1;
  assign isr_rank  = isr_hi[2:0] - lp_q - 3'd1;
  assign cand_ok   = cand[3] & (~isr_hi[3] | (cand_rank < isr_rank));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    spur_d    = spur_q;
    int_d     = 1'b0;
    irr_clr_d = '0;
    dout_d    = dout_q;
    den_d     = den_q;
    lp_d      = lp_q;
    set_mask  = '0;
    clr_mask  = '0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = ACK1;
          if (cand_ok) begin
            sel_d     = cand[2:0];
            spur_d    = 1'b0;
            set_mask  = 8'b1 << cand[2:0];
            irr_clr_d = 8'b1 << cand[2:0];
          end else begin
            // Request vanished before the acknowledge: answer with level 7.
            sel_d  = 3'd7;
            spur_d = 1'b1;
          end
        end else begin
          int_d = cand_ok;
        end
      end
      ACK1:  if (rise) state_d = WAIT2;
      WAIT2: begin
        if (fall) begin
          state_d = ACK2;
          dout_d  = {vector_base, sel_q};
          den_d   = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          state_d = IDLE;
          den_d   = 1'b0;
          if (aeoi_mode && !spur_q) begin
            clr_mask = clr_mask | (8'b1 << sel_q);
            if (rotate_mode) lp_d = sel_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Command EOIs come after AEOI so that their rotation overrides it.
    if (seoi) begin
      clr_mask = clr_mask | (8'b1 << seoi_level);
    end else if (eoi && isr_hi[3]) begin
      clr_mask = clr_mask | (8'b1 << isr_hi[2:0]);
      if (rotate_mode) lp_d = isr_hi[2:0];
    end

    // A set in the same cycle survives a clear of the same bit.
    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inta_q    <= 1'b1;
      sel_q     <= 3'd0;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
      irr_clr_q <= '0;
      isr_q     <= '0;
      dout_q    <= '0;
      den_q     <= 1'b0;
      lp_q      <= RESET_LOWEST_PRIO;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_n;
      sel_q     <= sel_d;
      spur_q    <= spur_d;
      int_q     <= int_d;
      irr_clr_q <= irr_clr_d;
      isr_q     <= isr_d;
      dout_q    <= dout_d;
      den_q     <= den_d;
      lp_q      <= lp_d;
    end
  end

  assign int_out     = int_q;
  assign irr_clr     = irr_clr_q;
  assign isr         = isr_q;
  assign data_out    = dout_q;
  assign data_en     = den_q;
  assign lowest_prio = lp_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_inta_sequencer
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural model (handshake phase counter + ring-rank arithmetic)
//   predicts every output and is compared with the DUT on each falling edge.
// ---------------------------------------------------------------------------
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr, imr;
  logic       inta_n, eoi, seoi;
  logic [2:0] seoi_level;
  logic       aeoi_mode, rotate_mode;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] irr_clr, isr, data_out;
  logic       data_en;
  logic [2:0] lowest_prio;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pic_inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta_n(inta_n),
    .eoi(eoi), .seoi(seoi), .seoi_level(seoi_level), .aeoi_mode(aeoi_mode),
    .rotate_mode(rotate_mode), .vector_base(vector_base), .int_out(int_out),
    .irr_clr(irr_clr), .isr(isr), .data_out(data_out), .data_en(data_en),
    .lowest_prio(lowest_prio)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ring order: level (lp+1)%8 first, lp last; rank 0 = highest priority.
  function automatic int best(input logic [7:0] v, input logic [2:0] lp);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = (int'(lp) + 1 + r) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int rank(input int l, input logic [2:0] lp);
    return (l - int'(lp) + 7) % 8;
  endfunction

  int         m_ph;      // 0 idle, 1 after 1st fall, 2 after rise, 3 vector phase
  logic       m_prev, m_spur, m_int, m_den;
  logic [7:0] m_isr, m_clr, m_dout;
  logic [2:0] m_lp, m_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_prev <= 1'b1; m_spur <= 1'b0; m_int <= 1'b0; m_den <= 1'b0;
      m_isr <= '0; m_clr <= '0; m_dout <= '0; m_lp <= 3'd7; m_sel <= 3'd0;
    end else begin : upd
      logic fall, rise, ok;
      logic [7:0] req, setm, clrm, nclr;
      logic [2:0] nlp;
      int c, h;
      fall = m_prev && !inta_n;
      rise = !m_prev && inta_n;
      req  = irr & ~imr;
      c    = best(req, m_lp);
      h    = best(m_isr, m_lp);
      ok   = (c >= 0) && ((h < 0) || (rank(c, m_lp) < rank(h, m_lp)));
      setm = '0; clrm = '0; nclr = '0; nlp = m_lp;
      m_prev <= inta_n;
      m_int  <= 1'b0;
      case (m_ph)
        0: begin
          if (fall) begin
            m_ph <= 1;
            if (ok) begin
              m_sel <= 3'(c); m_spur <= 1'b0; setm[c] = 1'b1; nclr[c] = 1'b1;
            end else begin
              m_sel <= 3'd7; m_spur <= 1'b1;
            end
          end else m_int <= ok;
        end
        1: if (rise) m_ph <= 2;
        2: if (fall) begin m_ph <= 3; m_dout <= {vector_base, m_sel}; m_den <= 1'b1; end
        default: if (rise) begin
          m_ph <= 0; m_den <= 1'b0;
          if (aeoi_mode && !m_spur) begin
            clrm[m_sel] = 1'b1;
            if (rotate_mode) nlp = m_sel;
          end
        end
      endcase
      if (seoi) clrm[seoi_level] = 1'b1;
      else if (eoi && h >= 0) begin
        clrm[h] = 1'b1;
        if (rotate_mode) nlp = 3'(h);
      end
      m_isr <= (m_isr & ~clrm) | setm;
      m_lp  <= nlp;
      m_clr <= nclr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("int_out", {7'd0, int_out}, {7'd0, m_int});
      chk("irr_clr", irr_clr, m_clr);
      chk("isr", isr, m_isr);
      chk("data_en", {7'd0, data_en}, {7'd0, m_den});
      chk("data_out", data_out, m_dout);
      chk("lowest_prio", {5'd0, lowest_prio}, {5'd0, m_lp});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ack(output logic [7:0] clr, output logic [7:0] vec, output logic den);
    inta_n = 1'b0; step(); clr = irr_clr;
    inta_n = 1'b1; step();
    inta_n = 1'b0; step(); vec = data_out; den = data_en;
    inta_n = 1'b1; step();
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  logic [7:0] c8, v8;
  logic       d1;

  initial begin
    rst_n = 1'b0; irr = '0; imr = '0; inta_n = 1'b1; eoi = 1'b0; seoi = 1'b0;
    seoi_level = '0; aeoi_mode = 1'b0; rotate_mode = 1'b0; vector_base = 5'b00001;
    #12 rst_n = 1'b1;
    chk_en = 1'b1;
    step();
    chk("rst_isr", isr, 8'h00);
    chk("rst_lp", {5'd0, lowest_prio}, 8'd7);
    chk("rst_int", {7'd0, int_out}, 8'd0);

    // Basic vector on IR7
    irr = 8'h80; step();
    chk("basic_int", {7'd0, int_out}, 8'd1);
    ack(c8, v8, d1);
    chk("basic_clr", c8, 8'h80);
    chk("basic_vec", v8, 8'h0F);
    chk("basic_den", {7'd0, d1}, 8'd1);
    chk("basic_isr", isr, 8'h80);
    irr = 8'h00; pulse_eoi();
    chk("basic_eoi", isr, 8'h00);

    // Fully nested priority
    irr = 8'hFF; step();
    chk("prio_int", {7'd0, int_out}, 8'd1);
    ack(c8, v8, d1);
    chk("prio_clr", c8, 8'h01);
    chk("prio_vec", v8, 8'h08);
    chk("prio_isr", isr, 8'h01);
    irr = 8'hFE; step(); step();
    chk("prio_blocked", {7'd0, int_out}, 8'd0);
    pulse_eoi(); step();
    chk("prio_reint", {7'd0, int_out}, 8'd1);
    ack(c8, v8, d1);
    chk("prio_vec1", v8, 8'h09);
    irr = 8'h00; pulse_eoi();
    chk("prio_clean", isr, 8'h00);

    // Nesting and masking
    irr = 8'h08; step(); ack(c8, v8, d1); irr = 8'h00;
    chk("nest_isr3", isr, 8'h08);
    irr = 8'h22; imr = 8'h02; step(); step();
    chk("nest_masked", {7'd0, int_out}, 8'd0);
    imr = 8'h00; step();
    chk("nest_int", {7'd0, int_out}, 8'd1);
    ack(c8, v8, d1); irr = 8'h00;
    chk("nest_clr", c8, 8'h02);
    chk("nest_isr", isr, 8'h0A);
    pulse_eoi();
    chk("nest_eoi", isr, 8'h08);
    seoi = 1'b1; seoi_level = 3'd3; step(); seoi = 1'b0;
    chk("nest_seoi", isr, 8'h00);

    // AEOI with rotation
    aeoi_mode = 1'b1; rotate_mode = 1'b1; irr = 8'h11; step();
    ack(c8, v8, d1);
    chk("aeoi_vec0", v8, 8'h08);
    chk("aeoi_isr", isr, 8'h00);
    chk("aeoi_lp0", {5'd0, lowest_prio}, 8'd0);
    step();
    chk("aeoi_int", {7'd0, int_out}, 8'd1);
    ack(c8, v8, d1);
    chk("aeoi_clr4", c8, 8'h10);
    chk("aeoi_vec4", v8, 8'h0C);
    chk("aeoi_lp4", {5'd0, lowest_prio}, 8'd4);
    rotate_mode = 1'b0; irr = 8'h00;

    // Spurious: request withdrawn before the first INTA
    irr = 8'h04; step();
    chk("spur_int", {7'd0, int_out}, 8'd1);
    irr = 8'h00; step();
    ack(c8, v8, d1);
    chk("spur_clr", c8, 8'h00);
    chk("spur_vec", v8, 8'h0F);
    chk("spur_isr", isr, 8'h00);
    chk("spur_lp", {5'd0, lowest_prio}, 8'd4);
    aeoi_mode = 1'b0;

    // Reset in the vector phase
    irr = 8'h01; step();
    inta_n = 1'b0; step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    chk("rst_mid_den", {7'd0, data_en}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_den0", {7'd0, data_en}, 8'd0);
    chk("rst_mid_isr", isr, 8'h00);
    chk("rst_mid_int", {7'd0, int_out}, 8'd0);
    chk("rst_mid_lp", {5'd0, lowest_prio}, 8'd7);
    @(negedge clk); rst_n = 1'b1; inta_n = 1'b1;
    step(); step();
    ack(c8, v8, d1);
    chk("post_rst_clr", c8, 8'h01);
    chk("post_rst_vec", v8, 8'h08);
    irr = 8'h00; pulse_eoi();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step();
      eoi = 1'b0; seoi = 1'b0;
      if ($urandom_range(3) == 0) inta_n = ~inta_n;
      if ($urandom_range(9) == 0) eoi = 1'b1;
      if ($urandom_range(15) == 0) begin seoi = 1'b1; seoi_level = 3'($urandom_range(7)); end
      if ($urandom_range(7) == 0) irr = 8'($urandom & $urandom);
      if ($urandom_range(15) == 0) imr = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(63) == 0) aeoi_mode = 1'($urandom);
      if ($urandom_range(63) == 0) rotate_mode = 1'($urandom);
      if ($urandom_range(127) == 0) vector_base = 5'($urandom);
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Interrupt service controller of the 8259 PIC core.
- Takes pending requests (IRR) and the mask register (IMR), and resolves priority internally using fully-nested or auto-rotate ordering.
- Raises INT and sequences the two-pulse INTA acknowledge cycle, then maintains the ISR and the rotation pointer.
- Sits between the IRR/IMR registers and the data-bus buffer; handles EOI commands from the command decoder.

Parameters:
- RESET_LOWEST_PRIO, 3'd7: lowest-priority level after reset, so IR0 is highest.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- irr  in  8  pending interrupt requests.
- imr  in  8  mask bits; 1 = masked.
- inta_n  in  1  active-low acknowledge, synchronous to clk.
- eoi  in  1  one-cycle non-specific EOI pulse.
- seoi  in  1  one-cycle specific EOI pulse.
- seoi_level  in  3  level cleared by seoi.
- aeoi_mode  in  1  automatic EOI at end of second INTA.
- rotate_mode  in  1  auto-rotate priority on EOI/AEOI.
- vector_base  in  5  ICW2 T7..T3.
- int_out  out  1  interrupt request to CPU.
- irr_clr  out  8  one-cycle one-hot pulse that clears the accepted IRR bit.
- isr  out  8  in-service register.
- data_out  out  8  vector byte.
- data_en  out  1  vector valid / bus-drive enable.
- lowest_prio  out  3  current lowest-priority level.

Behaviour:
- Reset (async, rst_n=0): int_out=0, irr_clr=0, isr=0, data_out=0, data_en=0, lowest_prio=RESET_LOWEST_PRIO, state=IDLE, inta_q=1. Reset mid-cycle aborts any acknowledge and leaves no ISR bit set.
- Edge detection: inta_q is inta_n registered. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- Priority: the highest-priority level is (lowest_prio+1) mod 8, descending cyclically to lowest_prio. Only req = irr & ~imr participates.
- Candidate: the highest-priority set bit of req. It is valid only if its priority is strictly higher than the highest-priority set ISR bit (or ISR is empty).
- IDLE:
  - int_out is registered: it reflects the candidate's validity 1 clk after the inputs change.
  - On fall: latch sel = candidate level.
  - If the candidate is valid: pulse irr_clr one-hot for 1 clk and set isr[sel]; spur=0.
  - Otherwise (spurious): sel=7, no irr_clr, no ISR change, spur=1.
  - In both cases clear int_out and go to ACK1.
- ACK1: int_out=0; on rise go to WAIT2.
- WAIT2: int_out=0; on fall go to ACK2.
- ACK2:
  - Entering ACK2: data_out={vector_base,sel} and data_en=1, both registered, valid 1 clk after the fall and held while inta_n stays low.
  - On rise: data_en=0 and return to IDLE.
  - If aeoi_mode and !spur: clear isr[sel]; if rotate_mode also, lowest_prio=sel.
- EOI:
  - eoi clears the highest-priority set ISR bit under the current rotation. If rotate_mode, lowest_prio becomes that level.
  - seoi clears isr[seoi_level] with no rotation.
  - Either one with nothing to clear is a no-op.
  - eoi and seoi in the same cycle: seoi wins.
- Simultaneous events: isr_next = (isr & ~clr_mask) | set_mask, so a set in the same cycle survives a clear of the same bit. EOI-driven rotation takes precedence over AEOI rotation.
- EOI is accepted in any state; the ISR update takes effect next clk, and int_out is re-evaluated afterwards in IDLE.
- Masking a request after the first INTA does not affect the latched sel.

Test Plan:
- Basic vector: vector_base=5'b00001, irr=0x80, imr=0 → int_out=1 after 1 clk. First INTA → irr_clr=0x80, isr=0x80. Second INTA → data_en=1, data_out=0x0F. eoi → isr=0x00.
- Priority order: irr=0xFF → sel=0, isr=0x01, data_out low bits 000. irr then 0xFE → int_out stays 0. eoi → int_out=1, next vector level 1.
- Nesting and masking: isr=0x08, irr=0x22, imr=0x02 → int_out=0. Set imr=0 → IR1 serviced, isr=0x0A. eoi → isr=0x08. seoi with seoi_level=3 → isr=0x00.
- AEOI with rotation: aeoi_mode=1, rotate_mode=1, irr=0x11 → IR0 served. At second INTA rise isr=0x00 and lowest_prio=0. Next cycle serves IR4 (level 4 vector); afterwards lowest_prio=4.
- Spurious: irr=0x04, int_out=1; drop irr to 0 before first INTA → irr_clr=0, isr=0, data_out={vector_base,3'd7}, ISR unchanged after AEOI.
- Reset mid-ACK2: assert rst_n=0 while data_en=1 → data_en=0, isr=0, int_out=0, lowest_prio=7 immediately. After release with irr=0x01, a normal sequence returns level 0.
